// File: rtl/memory_bus_master.sv
// CPU-side initiator for the 8-bit-data / 16-bit-address memory bus: splits one byte or word
// request into one or two byte bus cycles, then pulses done for a single cycle.
module memory_bus_master #(
  parameter int ADDR_WIDTH = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic                  word,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  hi_first;

  // Big-endian word accesses put the high byte on the first bus cycle (at addr).
  assign hi_first = BIG_ENDIAN & word_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path infers a latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d = BYTE0;
          we_d    = we;
          word_d  = word;
          addr_d  = addr;
          wdata_d = wdata;
        end else begin
          state_d = IDLE;
        end
      end
      BYTE0: begin
        if (!we_q) begin
          if (!word_q)       rdata_d = {8'h00, mem_rdata};
          else if (hi_first) rdata_d[15:8] = mem_rdata;
          else               rdata_d[7:0]  = mem_rdata;
        end
        state_d = word_q ? BYTE1 : DONE;
      end
      BYTE1: begin
        if (!we_q) begin
          if (hi_first) rdata_d[7:0]  = mem_rdata;
          else          rdata_d[15:8] = mem_rdata;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are decoded from the state so reset silences the bus immediately.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      BYTE0: begin
        mem_addr  = addr_q;
        mem_read  = ~we_q;
        mem_write = we_q;
        mem_wdata = hi_first ? wdata_q[15:8] : wdata_q[7:0];
      end
      BYTE1: begin
        mem_addr  = addr_q + ADDR_WIDTH'(1);
        mem_read  = ~we_q;
        mem_write = we_q;
        mem_wdata = hi_first ? wdata_q[7:0] : wdata_q[15:8];
      end
      default: ;
    endcase
  end

  assign busy  = (state_q == BYTE0) || (state_q == BYTE1);
  assign done  = (state_q == DONE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_memory_bus_master.sv
// Bench for memory_bus_master: a byte-array memory, an address-level reference model feeding
// beat and transfer scoreboards, and a negedge monitor that checks each bus beat and done pulse.
module tb_memory_bus_master;
  localparam int AW = 16;
  localparam bit BE = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, we = 1'b0, word = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [15:0]   wdata = '0;
  logic [15:0]   rdata;
  logic          busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_read, mem_write;

  logic [7:0] mem     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  typedef struct { logic w; logic [AW-1:0] a; logic [7:0] d; } beat_t;
  typedef struct { logic [15:0] rd; int cyc; } xfer_t;

  beat_t       bus_q[$];
  xfer_t       sb_q[$];
  beat_t       mb;
  xfer_t       mx;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] last_rd = '0;

  memory_bus_master #(.ADDR_WIDTH(AW), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .word(word), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read while read=1, write commits on the clock edge.
  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is a list of byte beats at addr and addr+1 plus a resulting rdata.
  function automatic void push_xfer(input logic w, input logic wd, input logic [AW-1:0] a,
                                    input logic [15:0] d, input int exp_cyc);
    logic [AW-1:0] a1;
    logic [7:0]    at_a, at_a1;
    a1 = a + AW'(1);
    if (wd && BE) begin at_a = d[15:8]; at_a1 = d[7:0];  end
    else          begin at_a = d[7:0];  at_a1 = d[15:8]; end
    if (w) begin
      bus_q.push_back('{1'b1, a, at_a});
      ref_mem[a] = at_a;
      if (wd) begin
        bus_q.push_back('{1'b1, a1, at_a1});
        ref_mem[a1] = at_a1;
      end
    end else begin
      bus_q.push_back('{1'b0, a, 8'h00});
      if (wd) bus_q.push_back('{1'b0, a1, 8'h00});
      if (!wd)     last_rd = {8'h00, ref_mem[a]};
      else if (BE) last_rd = {ref_mem[a], ref_mem[a1]};
      else         last_rd = {ref_mem[a1], ref_mem[a]};
    end
    sb_q.push_back('{last_rd, exp_cyc});
  endfunction

  // Called at a negedge; done is due 2 (byte) or 3 (word) cycles after req is raised.
  task automatic issue(input logic w, input logic wd, input logic [AW-1:0] a, input logic [15:0] d);
    int waited;
    waited = 0;
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("issue_wait_busy", {31'b0, busy}, 0);
    if (busy) return;
    req = 1'b1; we = w; word = wd; addr = a; wdata = d;
    push_xfer(w, wd, a, d, cyc + (wd ? 3 : 2));
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); word = 1'($urandom); addr = AW'($urandom); wdata = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_xfers", sb_q.size(), 0);
    check("drain_beats", bus_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read || mem_write) begin
        check("rw_exclusive", {31'b0, mem_read & mem_write}, 0);
        check("beat_expected", {31'b0, bus_q.size() != 0}, 1);
        if (bus_q.size() != 0) begin
          mb = bus_q.pop_front();
          check("beat_is_write", {31'b0, mem_write}, {31'b0, mb.w});
          check("beat_addr", {16'b0, mem_addr}, {16'b0, mb.a});
          if (mb.w) check("beat_wdata", {24'b0, mem_wdata}, {24'b0, mb.d});
        end
      end
      if (done) begin
        check("done_expected", {31'b0, sb_q.size() != 0}, 1);
        check("busy_in_done", {31'b0, busy}, 0);
        if (sb_q.size() != 0) begin
          mx = sb_q.pop_front();
          check("rdata", {16'b0, rdata}, {16'b0, mx.rd});
          check("done_cycle", cyc, mx.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra, ra1;
    logic [15:0]   rw;
    int            free_edge, e, bad;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h2000] = 8'h34; ref_mem[16'h2000] = 8'h34;
    mem[16'h2001] = 8'h12; ref_mem[16'h2001] = 8'h12;
    mem[16'h3000] = 8'h34; ref_mem[16'h3000] = 8'h34;
    mem[16'h3001] = 8'h12; ref_mem[16'h3001] = 8'h12;
    mem[16'h4000] = 8'h7F; ref_mem[16'h4000] = 8'h7F;

    repeat (3) @(negedge clk);
    check("reset_rdata", {16'b0, rdata}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_mem_read", {31'b0, mem_read}, 0);
    check("reset_mem_write", {31'b0, mem_write}, 0);
    check("reset_mem_addr", {16'b0, mem_addr}, 0);
    check("reset_mem_wdata", {24'b0, mem_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 1'b0, 16'h1234, 16'hABCD);
    issue(1'b0, 1'b1, 16'h2000, 16'h0000);
    issue(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    wait_drain();
    check("wrap_lo", {24'b0, mem[16'hFFFF]}, 32'hEF);
    check("wrap_hi", {24'b0, mem[16'h0000]}, 32'hBE);
    check("byte_write_mem", {24'b0, mem[16'h1234]}, 32'hCD);

    issue(1'b0, 1'b1, 16'h3000, 16'h0000);
    issue(1'b0, 1'b0, 16'h4000, 16'h0000);
    issue(1'b1, 1'b0, 16'h0100, 16'h5A5A);
    wait_drain();
    check("zero_extend_hold", {16'b0, rdata}, 32'h007F);

    // Hold req for six edges: only requests seen in IDLE/DONE are accepted.
    free_edge = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      req = 1'b1; we = 1'b0; word = 1'b1;
      addr = AW'($urandom_range(0, 63)); wdata = 16'($urandom);
      e = cyc + 1;
      if (e >= free_edge) begin
        push_xfer(1'b0, 1'b1, addr, wdata, e + 2);
        free_edge = e + 3;
      end
      @(negedge clk);
    end
    req = 1'b0;
    wait_drain();

    for (int n = 0; n < 300; n++) begin
      logic          w, wd;
      logic [AW-1:0] a;
      w  = 1'($urandom);
      wd = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'hFFFF - AW'($urandom_range(0, 1));
      else                           a = 16'h0100 + AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(w, wd, a, 16'($urandom));
    end
    wait_drain();

    // Reset during BYTE1 of a word write: byte0 is committed, byte1 never is.
    ra  = 16'h0200;
    ra1 = ra + AW'(1);
    rw  = 16'hC3A5;
    req = 1'b1; we = 1'b1; word = 1'b1; addr = ra; wdata = rw;
    bus_q.push_back('{1'b1, ra, rw[7:0]});
    ref_mem[ra] = rw[7:0];
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_write", {31'b0, mem_write}, 0);
    check("abort_mem_read", {31'b0, mem_read}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_rdata", {16'b0, rdata}, 0);
    check("abort_mem_addr", {16'b0, mem_addr}, 0);
    check("abort_mem_wdata", {24'b0, mem_wdata}, 0);
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_no_write", {31'b0, mem_write}, 0);
    check("after_reset_busy", {31'b0, busy}, 0);
    check("abort_byte0_committed", {24'b0, mem[ra]}, {24'b0, rw[7:0]});
    check("abort_byte1_untouched", {24'b0, mem[ra1]}, {24'b0, ref_mem[ra1]});
    check("abort_beats_consumed", bus_q.size(), 0);

    issue(1'b0, 1'b0, ra, 16'h0000);
    wait_drain();

    bad = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
